// File: rtl/ro_puf_pkg.sv
// Shared types and width helpers for the RO-PUF measurement controller.
// Optional DIFF output of the top is enabled by RO_PUF_DIFF_OUT_EN.
package ro_puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SETTLE,
      ST_MEASURE,
      ST_HOLD,
      ST_COMPARE,
      ST_NEXT,
      ST_DONE
   } state_e;

   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned FIN_BIT   = 14;

   // Bits needed to count 0..n-1 (at least one bit).
   function automatic int unsigned cnt_bits(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ro_puf_measure_ctrl_sync_2ff.sv
// Two-flop synchroniser for the asynchronous counter finished flags.
// Clears to 0 on reset.
module sync_2ff (
   input  logic CLK,
   input  logic RSTN,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) ff_q <= '0;
      else       ff_q <= {ff_q[0], d_i};
   end

   assign q_o = ff_q[1];

endmodule

// File: rtl/ro_puf_measure_ctrl.sv
// Sequencer running one RO-pair race per response bit.
// Define RO_PUF_DIFF_OUT_EN to add the signed DIFF (CNT_A-CNT_B) output.
module ro_puf_measure_ctrl
   import ro_puf_pkg::*;
#(
   parameter  int unsigned N_BITS     = 32,
   parameter  int unsigned CNT_W      = CNT_W_DEF,
   parameter  int unsigned SETTLE_CYC = 4,
   parameter  int unsigned HOLD_CYC   = 8,
   parameter  int unsigned TMO_W      = 20,
   localparam int unsigned SEL_W      = idx_width(N_BITS)
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic                    START,
   output logic [SEL_W-1:0]        SEL,
   output logic                    CNT_CLR,
   output logic                    CNT_CE,
   input  logic                    FIN_A,
   input  logic                    FIN_B,
   input  logic [CNT_W-1:0]        CNT_A,
   input  logic [CNT_W-1:0]        CNT_B,
   output logic                    BUSY,
   output logic                    DONE,
   output logic                    VALID,
   output logic                    ERR,
`ifdef RO_PUF_DIFF_OUT_EN
   output logic signed [CNT_W:0]   DIFF,
`endif
   output logic [N_BITS-1:0]       RESPONSE
);

   localparam int unsigned TMR_W = max3(TMO_W, cnt_bits(SETTLE_CYC),
                                        cnt_bits(HOLD_CYC));

   localparam logic [TMR_W-1:0] SET_LAST  = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
   // Last of the 2^TMO_W-1 permitted MEASURE cycles.
   localparam logic [TMR_W-1:0] TMO_LAST  =
      TMR_W'((64'd1 << TMO_W) - 64'd2);
   localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(N_BITS - 1);

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                tmo_q, tmo_d;
   logic                err_q, err_d;
   logic                valid_q, valid_d;
   logic [N_BITS-1:0]   resp_q, resp_d;
   logic                ce_q, clr_q;
   logic                fin_a_s, fin_b_s;

   sync_2ff u_sync_a (
      .CLK  (CLK),
      .RSTN (RSTN),
      .d_i  (FIN_A),
      .q_o  (fin_a_s)
   );

   sync_2ff u_sync_b (
      .CLK  (CLK),
      .RSTN (RSTN),
      .d_i  (FIN_B),
      .q_o  (fin_b_s)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmr_d   = tmr_q + 1'b1;
      tmo_d   = tmo_q;
      err_d   = err_q;
      valid_d = valid_q;
      resp_d  = resp_q;
      unique case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_CLEAR;
               idx_d   = '0;
               resp_d  = '0;
               err_d   = 1'b0;
               valid_d = 1'b0;
            end
         end
         ST_CLEAR: begin
            state_d = ST_SETTLE;
            tmo_d   = 1'b0;
         end
         ST_SETTLE: begin
            if (tmr_q == SET_LAST) state_d = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (fin_a_s || fin_b_s) begin
               state_d = ST_HOLD;
            end else if (tmr_q == TMO_LAST) begin
               state_d = ST_HOLD;
               tmo_d   = 1'b1;
               err_d   = 1'b1;
            end
         end
         ST_HOLD: begin
            if (tmr_q == HOLD_LAST) state_d = ST_COMPARE;
         end
         ST_COMPARE: begin
            // Ties and timed-out bits resolve to 0.
            resp_d[idx_q] = !tmo_q && (CNT_A > CNT_B);
            state_d       = ST_NEXT;
         end
         ST_NEXT: begin
            if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
               valid_d = 1'b1;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_CLEAR;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (state_d != state_q) tmr_d = '0;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         tmr_q   <= '0;
         tmo_q   <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         resp_q  <= '0;
         ce_q    <= 1'b0;
         clr_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmr_q   <= tmr_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         resp_q  <= resp_d;
         ce_q    <= (state_d == ST_MEASURE);
         clr_q   <= (state_d == ST_IDLE) || (state_d == ST_CLEAR);
      end
   end

`ifdef RO_PUF_DIFF_OUT_EN
   logic signed [CNT_W:0] diff_q;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         diff_q <= '0;
      end else if (state_q == ST_COMPARE) begin
         diff_q <= $signed({1'b0, CNT_A}) - $signed({1'b0, CNT_B});
      end
   end

   assign DIFF = diff_q;
`endif

   assign SEL      = idx_q;
   assign CNT_CLR  = clr_q;
   assign CNT_CE   = ce_q;
   assign BUSY     = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign DONE     = (state_q == ST_DONE);
   assign VALID    = valid_q;
   assign ERR      = err_q;
   assign RESPONSE = resp_q;

endmodule

// File: tb/tb_ro_puf_measure_ctrl.sv
// Bench for ro_puf_measure_ctrl with saturating RO counter models.
// Covers race results, ties, timeout, START-while-busy and mid-run reset.
module tb_ro_puf_measure_ctrl;

   localparam int N     = 4;
   localparam int SC    = 2;
   localparam int HC    = 3;
   localparam int TW    = 6;
   localparam int FIN_V = 16384;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        START = 1'b0;
   logic [1:0]  SEL;
   logic        CNT_CLR, CNT_CE;
   logic        FIN_A, FIN_B;
   logic [15:0] CNT_A, CNT_B;
   logic        BUSY, DONE, VALID, ERR;
   logic [N-1:0] RESPONSE;
`ifdef RO_PUF_DIFF_OUT_EN
   logic signed [16:0] DIFF;
   logic signed [16:0] diff_log [N];
`endif

   int tests = 0;
   int fails = 0;
   int unsigned ra [N];
   int unsigned rb [N];
   int ce_tot [N];
   int busy_tot = 0;
   int done_tot = 0;

   ro_puf_measure_ctrl #(
      .N_BITS     (N),
      .CNT_W      (16),
      .SETTLE_CYC (SC),
      .HOLD_CYC   (HC),
      .TMO_W      (TW)
   ) dut (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .START    (START),
      .SEL      (SEL),
      .CNT_CLR  (CNT_CLR),
      .CNT_CE   (CNT_CE),
      .FIN_A    (FIN_A),
      .FIN_B    (FIN_B),
      .CNT_A    (CNT_A),
      .CNT_B    (CNT_B),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .VALID    (VALID),
      .ERR      (ERR),
`ifdef RO_PUF_DIFF_OUT_EN
      .DIFF     (DIFF),
`endif
      .RESPONSE (RESPONSE)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] sat(input logic [15:0] c,
                                       input int unsigned r);
      int unsigned s;
      s = int'(c) + r;
      return (s >= FIN_V) ? 16'h4000 : 16'(s);
   endfunction

   // RO counters: advance by a per-pair rate per enabled cycle, stop at finish.
   always @(posedge CLK) begin
      if (CNT_CLR) begin
         CNT_A <= '0;
         CNT_B <= '0;
      end else if (CNT_CE) begin
         CNT_A <= sat(CNT_A, ra[SEL]);
         CNT_B <= sat(CNT_B, rb[SEL]);
      end
   end

   assign FIN_A = CNT_A[14];
   assign FIN_B = CNT_B[14];

   always @(posedge CLK) begin
      if (CNT_CE === 1'b1) ce_tot[SEL] <= ce_tot[SEL] + 1;
      if (BUSY === 1'b1) busy_tot <= busy_tot + 1;
      if (DONE === 1'b1) done_tot <= done_tot + 1;
   end

`ifdef RO_PUF_DIFF_OUT_EN
   always @(negedge CLK) begin
      if (BUSY === 1'b1 && CNT_CLR === 1'b1 && SEL != 2'd0)
         diff_log[SEL-1] <= DIFF;
   end
`endif

   // CE cycles: finish edge of the faster RO, plus sync and FSM reaction.
   function automatic int unsigned meas_len(input int unsigned a,
                                            input int unsigned b);
      int unsigned f;
      f = (a > b) ? a : b;
      if (f == 0) return (1 << TW) - 1;
      return (FIN_V + f - 1) / f + 3;
   endfunction

   function automatic int unsigned fin_cnt(input int unsigned r,
                                           input int unsigned m);
      return (r * m > FIN_V) ? FIN_V : r * m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done();
      for (int c = 0; c < 3000; c++) begin
         if (DONE === 1'b1) break;
         @(negedge CLK);
      end
      chk("done_seen", DONE, 1);
   endtask

   task automatic rand_rates();
      for (int i = 0; i < N; i++) begin
         ra[i] = $urandom_range(1600, 500);
         rb[i] = $urandom_range(1600, 500);
      end
   endtask

   task automatic expect_run(output logic [N-1:0] er, output logic ee,
                             output int eb, output int em [N],
                             output int ed [N]);
      int unsigned m, fa, fb;
      er = '0;
      ee = 1'b0;
      eb = 0;
      for (int i = 0; i < N; i++) begin
         m  = meas_len(ra[i], rb[i]);
         fa = fin_cnt(ra[i], m);
         fb = fin_cnt(rb[i], m);
         if (ra[i] == 0 && rb[i] == 0) ee = 1'b1;
         er[i] = (fa > fb);
         em[i] = int'(m);
         ed[i] = int'(fa) - int'(fb);
         eb += 1 + SC + int'(m) + HC + 2;
      end
   endtask

   task automatic do_run(input bit pulse_busy);
      logic [N-1:0] er;
      logic ee;
      int eb, b0, d0;
      int em [N];
      int ed [N];
      int c0 [N];
      expect_run(er, ee, eb, em, ed);
      c0 = ce_tot;
      b0 = busy_tot;
      d0 = done_tot;
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      chk("busy_on", BUSY, 1);
      chk("sel_start", SEL, 0);
      if (pulse_busy) begin
         repeat (6) @(negedge CLK);
         START = 1'b1;
         @(negedge CLK);
         START = 1'b0;
      end
      wait_done();
      chk("busy_off", BUSY, 0);
      chk("valid", VALID, 1);
      chk("response", RESPONSE, er);
      chk("err", ERR, ee);
      chk("busy_cycles", busy_tot - b0, eb);
      for (int i = 0; i < N; i++)
         chk($sformatf("ce_len%0d", i), ce_tot[i] - c0[i], em[i]);
`ifdef RO_PUF_DIFF_OUT_EN
      for (int i = 0; i < N - 1; i++)
         chk($sformatf("diff%0d", i), 64'(diff_log[i]),
             64'(17'(ed[i])));
      chk("diff_last", 64'(DIFF), 64'(17'(ed[N-1])));
`endif
      @(negedge CLK);
      chk("done_pulse", DONE, 0);
      chk("done_count", done_tot - d0, 1);
      chk("valid_hold", VALID, 1);
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      chk("rst_sel", SEL, 0);
      chk("rst_clr", CNT_CLR, 1);
      chk("rst_ce", CNT_CE, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_valid", VALID, 0);
      chk("rst_err", ERR, 0);
      chk("rst_resp", RESPONSE, 0);
`ifdef RO_PUF_DIFF_OUT_EN
      chk("rst_diff", 64'(DIFF), 0);
`endif
      RSTN = 1'b1;
      @(negedge CLK);

      // Directed plan: A wins 0 and 2, tie on 1, timeout on 3.
      ra[0] = 1300; rb[0] = 1016;
      ra[1] = 1024; rb[1] = 1024;
      ra[2] = $urandom_range(1600, 900);
      rb[2] = $urandom_range((FIN_V - 1) / meas_len(ra[2], 0), 400);
      ra[3] = 0;    rb[3] = 0;
      do_run(1'b0);
      chk("resp_plan", RESPONSE, 4'b0101);
      chk("err_plan", ERR, 1);

      rand_rates();
      do_run(1'b1);

      // Mid-run reset during pair 2.
      rand_rates();
      ra[0] = 1500; rb[0] = 600;
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (SEL == 2'd2 && CNT_CE === 1'b1) break;
         @(negedge CLK);
      end
      chk("rst_reach", (SEL == 2'd2 && CNT_CE === 1'b1), 1);
      chk("pre_rst_bit0", RESPONSE[0], 1);
      #2 RSTN = 1'b0;
      #1;
      chk("arst_ce", CNT_CE, 0);
      chk("arst_clr", CNT_CLR, 1);
      chk("arst_resp", RESPONSE, 0);
      chk("arst_busy", BUSY, 0);
      chk("arst_sel", SEL, 0);
      @(negedge CLK);
      RSTN = 1'b1;
      @(negedge CLK);
      do_run(1'b0);

      // START held across DONE starts the next run right after IDLE.
      rand_rates();
      @(negedge CLK); START = 1'b1;
      @(negedge CLK);
      wait_done();
      chk("hold_busy_off", BUSY, 0);
      @(negedge CLK);
      chk("hold_idle", BUSY, 0);
      @(negedge CLK);
      chk("hold_restart", BUSY, 1);
      chk("hold_sel", SEL, 0);
      chk("hold_valid_clr", VALID, 0);
      START = 1'b0;
      wait_done();
      chk("hold_valid", VALID, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
